// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM request arbiter: FSM states, burst-engine
// command codes and the field boundaries of the {bank,row,col} address.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_BUSY  = 3'd2,
    ST_ACK   = 3'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    CMD_NOP     = 2'b00,
    CMD_REFRESH = 2'b01,
    CMD_WRITE   = 2'b10,
    CMD_READ    = 2'b11
  } eng_cmd_t;

  localparam int BANK_MSB = 23;
  localparam int BANK_LSB = 22;
  localparam int ROW_MSB  = 21;
  localparam int ROW_LSB  = 9;
  localparam int COL_MSB  = 8;
  localparam int COL_LSB  = 0;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: down-counter that raises ref_pend on every
// terminal count and flags ref_miss if the previous refresh was never taken.
module sdram_ref_timer
  import sdram_arb_pkg::*;
#(
  parameter int REF_INTERVAL = 1040
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ref_ack,
  output logic ref_pend,
  output logic ref_miss
);

  localparam int CNT_W = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(REF_INTERVAL - 1);

  logic [CNT_W-1:0] cnt;
  logic             reload;

  assign reload = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= RELOAD;
      ref_pend <= 1'b0;
      ref_miss <= 1'b0;
    end else begin
      cnt <= reload ? RELOAD : cnt - 1'b1;
      // a new interval wins over an acceptance landing on the same edge
      if (reload)
        ref_pend <= 1'b1;
      else if (ref_ack)
        ref_pend <= 1'b0;
      if (reload && ref_pend && !ref_ack)
        ref_miss <= 1'b1;
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Grants one camera-write / VGA-read page burst at a time, interleaves refresh.
// Optional grant counters are enabled by defining ARB_GRANT_STATS_EN.
//
// state | meaning
// IDLE  | pick refresh / write / read, latch command and address
// ISSUE | eng_valid high until the engine accepts
// BUSY  | waiting for eng_done
// ACK   | one-cycle ack to the served requester
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W       = 24,
  parameter int REF_INTERVAL = 1040,
  parameter int ACK_HOLDOFF  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_sdram_req,
  input  logic [ADDR_W-1:0] wr_sdram_add,
  output logic              wr_sdram_ack,
  input  logic              rd_sdram_req,
  input  logic [ADDR_W-1:0] rd_sdram_add,
  output logic              rd_sdram_ack,
  output logic              eng_valid,
  output logic [1:0]        eng_cmd,
  output logic [ADDR_W-1:0] eng_addr,
  input  logic              eng_ready,
  input  logic              eng_done,
  output logic [2:0]        arb_state,
  output logic              ref_miss,
  output logic [15:0]       wr_grants,
  output logic [15:0]       rd_grants
);

  localparam logic [1:0] HOLD = 2'(ACK_HOLDOFF);

  arb_state_t        state, state_nxt;
  eng_cmd_t          cmd_q, cmd_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              last_rd;
  logic [1:0]        hold_cnt;
  logic              hold_rd;
  logic              wr_ok, rd_ok;
  logic              ref_pend, ref_ack;

  sdram_ref_timer #(.REF_INTERVAL(REF_INTERVAL)) u_ref_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .ref_ack  (ref_ack),
    .ref_pend (ref_pend),
    .ref_miss (ref_miss)
  );

  // the just-served requester still shows its stale req for a few cycles
  assign wr_ok = wr_sdram_req && !((hold_cnt != 2'd0) && !hold_rd);
  assign rd_ok = rd_sdram_req && !((hold_cnt != 2'd0) &&  hold_rd);

  assign ref_ack = (state == ST_ISSUE) && eng_ready && (cmd_q == CMD_REFRESH);

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    addr_nxt  = addr_q;
    case (state)
      ST_IDLE: begin
        if (ref_pend) begin
          cmd_nxt   = CMD_REFRESH;
          addr_nxt  = '0;
          state_nxt = ST_ISSUE;
        end else if (wr_ok && (!rd_ok || last_rd)) begin
          cmd_nxt   = CMD_WRITE;
          addr_nxt  = wr_sdram_add;
          state_nxt = ST_ISSUE;
        end else if (rd_ok) begin
          cmd_nxt   = CMD_READ;
          addr_nxt  = rd_sdram_add;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: if (eng_ready) state_nxt = ST_BUSY;
      ST_BUSY:  if (eng_done)  state_nxt = (cmd_q == CMD_REFRESH) ? ST_IDLE : ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cmd_q    <= CMD_NOP;
      addr_q   <= '0;
      last_rd  <= 1'b1;
      hold_cnt <= 2'd0;
      hold_rd  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cmd_q  <= cmd_nxt;
      addr_q <= addr_nxt;
      if (state == ST_ACK) begin
        last_rd  <= (cmd_q == CMD_READ);
        hold_rd  <= (cmd_q == CMD_READ);
        hold_cnt <= HOLD;
      end else if (hold_cnt != 2'd0) begin
        hold_cnt <= hold_cnt - 2'd1;
      end
    end
  end

  assign eng_valid    = (state == ST_ISSUE);
  assign eng_cmd      = cmd_q;
  assign eng_addr     = addr_q;
  assign arb_state    = state;
  assign wr_sdram_ack = (state == ST_ACK) && (cmd_q == CMD_WRITE);
  assign rd_sdram_ack = (state == ST_ACK) && (cmd_q == CMD_READ);

`ifdef ARB_GRANT_STATS_EN
  logic [15:0] wr_cnt, rd_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_cnt <= 16'd0;
      rd_cnt <= 16'd0;
    end else begin
      if (wr_sdram_ack && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
      if (rd_sdram_ack && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 16'd1;
    end
  end

  assign wr_grants = wr_cnt;
  assign rd_grants = rd_cnt;
`else
  assign wr_grants = 16'd0;
  assign rd_grants = 16'd0;
`endif

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed bench for sdram_req_arbiter: reset, single write, round-robin,
// refresh priority, refresh miss and grant statistics.
module tb_sdram_req_arbiter;
  import sdram_arb_pkg::*;

  localparam int ADDR_W       = 24;
  localparam int REF_INTERVAL = 300;
  localparam int ACK_HOLDOFF  = 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_req = 1'b0, rd_req = 1'b0;
  logic [ADDR_W-1:0] wr_add = '0, rd_add = '0;
  logic              wr_ack, rd_ack;
  logic              eng_valid;
  logic [1:0]        eng_cmd;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_ready = 1'b0, eng_done = 1'b0;
  logic [2:0]        arb_state;
  logic              ref_miss;
  logic [15:0]       wr_grants, rd_grants;

  int checks = 0;
  int errors = 0;
  int n;
  logic [15:0] exp_wr_g, exp_rd_g;

  always #5 clk = ~clk;

  sdram_req_arbiter #(
    .ADDR_W(ADDR_W), .REF_INTERVAL(REF_INTERVAL), .ACK_HOLDOFF(ACK_HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_sdram_req(wr_req), .wr_sdram_add(wr_add), .wr_sdram_ack(wr_ack),
    .rd_sdram_req(rd_req), .rd_sdram_add(rd_add), .rd_sdram_ack(rd_ack),
    .eng_valid(eng_valid), .eng_cmd(eng_cmd), .eng_addr(eng_addr),
    .eng_ready(eng_ready), .eng_done(eng_done),
    .arb_state(arb_state), .ref_miss(ref_miss),
    .wr_grants(wr_grants), .rd_grants(rd_grants)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr_req = 1'b0; rd_req = 1'b0; eng_ready = 1'b0; eng_done = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!eng_valid && k < 50) begin
      tick();
      k++;
    end
    chk({tag, "_valid"}, 32'(eng_valid), 32'd1);
  endtask

  task automatic do_burst(input string tag, input logic [1:0] c, input logic [ADDR_W-1:0] a);
    wait_valid(tag);
    chk({tag, "_cmd"}, 32'(eng_cmd), 32'(c));
    chk({tag, "_addr"}, 32'(eng_addr), 32'(a));
    eng_ready = 1'b1; tick(); eng_ready = 1'b0;
    chk({tag, "_busy"}, 32'(arb_state), 32'd2);
    repeat (3) tick();
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk({tag, "_wack"}, 32'(wr_ack), 32'(c == 2'b10));
    chk({tag, "_rack"}, 32'(rd_ack), 32'(c == 2'b11));
    tick();
    chk({tag, "_ack_off"}, 32'({wr_ack, rd_ack}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset and idle refresh timing
    repeat (4) tick();
    rst_n = 1'b1;
    chk("rst_state", 32'(arb_state), 32'd0);
    chk("rst_valid", 32'(eng_valid), 32'd0);
    chk("rst_cmd",   32'(eng_cmd),   32'd0);
    chk("rst_addr",  32'(eng_addr),  32'd0);
    chk("rst_acks",  32'({wr_ack, rd_ack}), 32'd0);
    chk("rst_miss",  32'(ref_miss),  32'd0);
    chk("rst_grants", {wr_grants, rd_grants}, 32'd0);
    n = 0;
    while (!eng_valid && n < 400) begin
      tick();
      n++;
    end
    chk("ref_first_latency", 32'(n), 32'(REF_INTERVAL + 1));
    chk("ref_first_cmd",  32'(eng_cmd),  32'b01);
    chk("ref_first_addr", 32'(eng_addr), 32'd0);
    chk("ref_first_state", 32'(arb_state), 32'd1);

    // single write
    do_reset();
    wr_req = 1'b1; wr_add = 24'h400200; eng_ready = 1'b1;
    tick();
    chk("sw_valid", 32'(eng_valid), 32'd1);
    chk("sw_cmd",   32'(eng_cmd),   32'b10);
    chk("sw_addr",  32'(eng_addr),  32'h400200);
    wr_add = 24'hABCDEF;
    tick();
    eng_ready = 1'b0;
    chk("sw_busy_valid", 32'(eng_valid), 32'd0);
    chk("sw_busy_state", 32'(arb_state), 32'd2);
    repeat (19) tick();
    chk("sw_wait_state", 32'(arb_state), 32'd2);
    eng_done = 1'b1;
    chk("sw_ack_early", 32'(wr_ack), 32'd0);
    tick();
    eng_done = 1'b0;
    chk("sw_ack",       32'(wr_ack),    32'd1);
    chk("sw_rd_ack",    32'(rd_ack),    32'd0);
    chk("sw_ack_state", 32'(arb_state), 32'd3);
    chk("sw_addr_hold", 32'(eng_addr),  32'h400200);
    tick();
    chk("sw_ack_width", 32'(wr_ack),    32'd0);
    chk("sw_idle",      32'(arb_state), 32'd0);
    tick();
    chk("sw_mask_stale", 32'(arb_state), 32'd0);
    wr_req = 1'b0;
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (4) tick();
    chk("sw_no_regrant", 32'(eng_valid), 32'd0);
    chk("sw_done_ignored", 32'({arb_state, wr_ack, rd_ack}), 32'd0);

    // simultaneous requests alternate
    do_reset();
    wr_add = 24'h111111; rd_add = 24'h222222;
    wr_req = 1'b1; rd_req = 1'b1;
    do_burst("rr_w0", 2'b10, 24'h111111);
    do_burst("rr_r0", 2'b11, 24'h222222);
    do_burst("rr_w1", 2'b10, 24'h111111);
    do_burst("rr_r1", 2'b11, 24'h222222);
    wr_req = 1'b0; rd_req = 1'b0;

    // refresh becomes pending during a long write; it goes ahead of the read
    do_reset();
    wr_req = 1'b1; rd_req = 1'b1;
    wait_valid("rp_w");
    chk("rp_w_cmd", 32'(eng_cmd), 32'b10);
    eng_ready = 1'b1; tick(); eng_ready = 1'b0;
    repeat (320) tick();
    chk("rp_w_busy", 32'(arb_state), 32'd2);
    chk("rp_no_miss", 32'(ref_miss), 32'd0);
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    chk("rp_w_ack", 32'(wr_ack), 32'd1);
    tick();
    do_burst("rp_ref", 2'b01, 24'h000000);
    do_burst("rp_rd",  2'b11, 24'h222222);
    wr_req = 1'b0; rd_req = 1'b0;

    // refresh stalled in ISSUE for two intervals
    do_reset();
    repeat (310) tick();
    chk("rm_valid", 32'(eng_valid), 32'd1);
    chk("rm_cmd",   32'(eng_cmd),   32'b01);
    chk("rm_miss_before", 32'(ref_miss), 32'd0);
    repeat (300) tick();
    chk("rm_miss_set", 32'(ref_miss),  32'd1);
    chk("rm_state",    32'(arb_state), 32'd1);
    eng_ready = 1'b1; tick(); eng_ready = 1'b0;
    eng_done = 1'b1; tick(); eng_done = 1'b0;
    repeat (3) tick();
    chk("rm_miss_sticky", 32'(ref_miss), 32'd1);

    // grant statistics
    do_reset();
    wr_add = 24'h000123; rd_add = 24'h3F0000;
    wr_req = 1'b1;
    for (int i = 0; i < 3; i++) do_burst("st_w", 2'b10, 24'h000123);
    wr_req = 1'b0; rd_req = 1'b1;
    for (int i = 0; i < 5; i++) do_burst("st_r", 2'b11, 24'h3F0000);
    rd_req = 1'b0;
    repeat (3) tick();
`ifdef ARB_GRANT_STATS_EN
    exp_wr_g = 16'd3; exp_rd_g = 16'd5;
`else
    exp_wr_g = 16'd0; exp_rd_g = 16'd0;
`endif
    chk("st_wr_grants", 32'(wr_grants), 32'(exp_wr_g));
    chk("st_rd_grants", 32'(rd_grants), 32'(exp_rd_g));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Responder end of the wr_sdram_req/ack and rd_sdram_req/ack handshakes driven by the camera-write and VGA-read sequencers.
- Grants one page burst at a time and interleaves periodic auto-refresh.
- Forwards each granted operation to the SDRAM burst engine over a valid/ready/done interface.
- Sits inside the SDRAM subsystem in the clk_133M domain, between the frame-buffer sequencers and the command engine.

Parameters:
- ADDR_W, 24, width of request address ({bank[23:22], row[21:9], col[8:0]}).
- REF_INTERVAL, 1040, clk cycles between refresh requests (7.8 us at 133 MHz).
- ACK_HOLDOFF, 1, cycles a just-acked channel is masked in IDLE; legal values 1..3.

Ports:
- clk  in  1  system clock (clk_133M).
- rst_n  in  1  synchronous reset, active low.
- wr_sdram_req  in  1  write burst request; level, held until ack.
- wr_sdram_add  in  ADDR_W  write burst start address.
- wr_sdram_ack  out  1  one-cycle pulse; the write burst has completed.
- rd_sdram_req  in  1  read burst request; level, held until ack.
- rd_sdram_add  in  ADDR_W  read burst start address.
- rd_sdram_ack  out  1  one-cycle pulse; the read burst has completed.
- eng_valid  out  1  command valid to the burst engine.
- eng_cmd  out  2  00 NOP, 01 REFRESH, 10 WRITE, 11 READ.
- eng_addr  out  ADDR_W  address for WRITE/READ; zero for REFRESH.
- eng_ready  in  1  engine accepts the command when eng_valid && eng_ready.
- eng_done  in  1  one-cycle pulse; the accepted command has finished.
- arb_state  out  3  current FSM state, for debug and LEDs.
- ref_miss  out  1  sticky; a refresh interval elapsed while a refresh was still pending.
- wr_grants  out  16  saturating write-grant count (optional feature).
- rd_grants  out  16  saturating read-grant count (optional feature).

Behaviour:
- Reset (rst_n low at a clk edge) clears everything: acks 0, eng_valid 0, eng_cmd 00, eng_addr 0, arb_state IDLE, ref_miss 0, counters 0, ref_pend 0, last_grant=READ, masks clear.
- Refresh timer:
  - Counts down from REF_INTERVAL-1.
  - At 0 it reloads and sets ref_pend.
  - If ref_pend is already 1 at reload, ref_miss sets and stays set until reset.
- States (3-bit encoding): IDLE=0, ISSUE=1, BUSY=2, ACK=3.
- IDLE selects the next command, highest priority first:
  - ref_pend → REFRESH.
  - Only one unmasked request among wr/rd → that request.
  - Both unmasked → round-robin against last_grant (the one not granted last).
  - Selection latches eng_cmd and eng_addr (the request address, sampled that cycle) and moves to ISSUE.
- ISSUE:
  - eng_valid=1.
  - On eng_ready, ref_pend clears if the command is REFRESH, then → BUSY.
  - eng_cmd and eng_addr stay stable while waiting.
- BUSY:
  - eng_valid=0; waits for eng_done.
  - On eng_done: a REFRESH command returns to IDLE; WRITE/READ goes to ACK.
- ACK:
  - Exactly one cycle with the matching ack=1.
  - last_grant updates, and that channel is masked for ACK_HOLDOFF cycles after ACK.
  - → IDLE.
  - Purpose of the mask: the requester drops req on the edge at which it samples ack, so without it the arbiter would see a stale req and double-grant.
- Latency: request to eng_valid is 1 cycle (IDLE register then ISSUE). eng_done to ack is 1 cycle.
- eng_done outside BUSY is ignored. eng_ready outside ISSUE is ignored.
- A request dropped before grant is simply not served; no error.
- Request address changes after the grant are ignored.
- A timer reload in the same cycle as REFRESH acceptance: ref_pend stays 1 (set wins) and ref_miss is not flagged.
- Reset mid-burst returns to IDLE immediately; the engine is reset by the same rst_n.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- Defined:
  - wr_grants/rd_grants increment on each WRITE/READ ACK cycle.
  - Saturate at 16'hFFFF; reset to 0.
- Undefined:
  - No counter logic; wr_grants/rd_grants are tied to 0.
  - Ports remain present so the port list is identical.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding constants (IDLE/ISSUE/BUSY/ACK);
  - eng_cmd encodings (CMD_NOP/REFRESH/WRITE/READ);
  - bit positions of bank/row/col in the address.
- Sub-module sdram_ref_timer: down-counter, ref_pend set/clear, ref_miss. Inputs are ref_ack and the rst_n/clk pair.

Test Plan:
- Reset/idle: hold rst_n low 4 cycles, then no requests → all outputs 0, arb_state=0. After REF_INTERVAL cycles, eng_valid=1 with eng_cmd=01.
- Single write: wr_sdram_req=1, wr_sdram_add=24'h40_0200, eng_ready=1, eng_done 20 cycles later → eng_addr=24'h400200, eng_cmd=10, wr_sdram_ack one cycle exactly 1 cycle after eng_done, req dropped → no second grant.
- Simultaneous wr+rd held continuously (requester re-raises after ACK_HOLDOFF) → grants alternate WRITE, READ, WRITE, READ; neither ack is ever two-wide.
- Refresh priority: ref_pend set while wr_sdram_req and rd_sdram_req are both high → REFRESH issued first, then the round-robin request.
- Refresh miss: eng_ready held 0 for 2×REF_INTERVAL with a REFRESH in ISSUE → ref_miss=1 and stays 1 after eng_ready returns.
- Stats (ARB_GRANT_STATS_EN): 3 writes and 5 reads completed → wr_grants=3, rd_grants=5. Without the macro, both read 0.
